// File: rtl/onn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : onn_ctrl_pkg
// Description : Shared types and helpers for the oscillatory-network run
//               controller: FSM state encoding, default phase width and a
//               modular phase-difference function.
// Revision    : 1.0 - initial release
// ============================================================================
package onn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    FIN   = 3'd4
  } state_e;

  localparam int PHI_W_DEF = 4;
  // Widest phase field the difference helper supports.
  localparam int PHI_MAX_W = 8;

  // Phase difference a-b. Callers keep only the low PHI_W bits, which is
  // exactly the modulo-2^PHI_W result because subtraction wraps cleanly.
  function automatic logic [PHI_MAX_W-1:0] phase_diff(
    input logic [PHI_MAX_W-1:0] a,
    input logic [PHI_MAX_W-1:0] b
  );
    return a - b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/onn_stability_checker.sv
`default_nettype none
// ============================================================================
// Module      : onn_stability_checker
// Description : Holds the phase snapshot from the previous CHECK, compares it
//               with the live bank phases and counts consecutive unchanged
//               periods. Raises 'stable' combinationally in the CHECK cycle
//               whose comparison brings the count to STABLE_PERIODS.
// Config      : ONN_RELPHASE_EN - compare/expose phases relative to neuron 0
//               (global rotation counts as stable). Undefined: absolute.
// Ports       : clk, rst_n      - clock, async active-low reset
//               clear           - drop snapshot and count (new run)
//               check           - one-cycle compare strobe
//               phi_in          - flattened bank phases
//               stable          - convergence reached in this check
//               phi_view        - phases as compared (abs or relative)
// Revision    : 1.0 - initial release
// ============================================================================
module onn_stability_checker
  import onn_ctrl_pkg::*;
#(
  parameter int N_NEURONS      = 15,
  parameter int PHI_W          = PHI_W_DEF,
  parameter int STABLE_PERIODS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       check,
  input  logic [N_NEURONS*PHI_W-1:0] phi_in,
  output logic                       stable,
  output logic [N_NEURONS*PHI_W-1:0] phi_view
);

  localparam int VEC_W = N_NEURONS * PHI_W;
  localparam int CNT_W = $clog2(STABLE_PERIODS + 1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_PERIODS);

  logic [VEC_W-1:0] snap_q, snap_d;
  logic             snap_valid_q, snap_valid_d;
  logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
  logic             equal;

`ifdef ONN_RELPHASE_EN
  for (genvar i = 0; i < N_NEURONS; i++) begin : g_rel
    logic [PHI_MAX_W-1:0] diff_full;
    assign diff_full = phase_diff(PHI_MAX_W'(phi_in[i*PHI_W +: PHI_W]),
                                  PHI_MAX_W'(phi_in[0 +: PHI_W]));
    assign phi_view[i*PHI_W +: PHI_W] = diff_full[PHI_W-1:0];
  end
`else
  assign phi_view = phi_in;
`endif

  // An invalid snapshot (first check of a run) never matches.
  assign equal = snap_valid_q && (phi_view == snap_q);

  always_comb begin
    snap_d       = snap_q;
    snap_valid_d = snap_valid_q;
    stable_cnt_d = stable_cnt_q;
    if (clear) begin
      snap_d       = '0;
      snap_valid_d = 1'b0;
      stable_cnt_d = '0;
    end else if (check) begin
      snap_d       = phi_view;
      snap_valid_d = 1'b1;
      if (equal) begin
        // Saturate so a long-stable pattern cannot wrap the count.
        stable_cnt_d = (stable_cnt_q == CNT_TARGET) ? stable_cnt_q
                                                    : stable_cnt_q + 1'b1;
      end else begin
        stable_cnt_d = '0;
      end
    end
  end

  assign stable = check && !clear && (stable_cnt_d == CNT_TARGET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
      stable_cnt_q <= '0;
    end else begin
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
      stable_cnt_q <= stable_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/onn_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : onn_run_controller
// Description : Sequences one relaxation of a serial-load oscillatory neuron
//               bank: serial pattern load, oscillation with period strobe,
//               stability/timeout detection and result latching.
// Config      : ONN_RELPHASE_EN - relative-phase comparison and result
//               (handled inside onn_stability_checker).
// Ports       : clk, rst_n   - clock, async active-low reset
//               start        - run request (ignored while busy / in FIN)
//               pattern      - initial state, bit i ends in neuron i
//               phi_in       - flattened bank phases
//               ser_bit      - serial data to chain head
//               ser_shift    - chain shift strobe
//               re           - run enable (RUN/CHECK)
//               full_tick    - one-cycle period strobe
//               busy, done   - run in progress / one-cycle end pulse
//               converged    - run ended by stability
//               result       - phases latched at run end
//               periods      - full_tick count, saturating at 255
// Revision    : 1.0 - initial release
// ============================================================================
module onn_run_controller
  import onn_ctrl_pkg::*;
#(
  parameter int N_NEURONS      = 15,
  parameter int PHI_W          = PHI_W_DEF,
  parameter int TICK_DIV       = 16,
  parameter int STABLE_PERIODS = 4,
  parameter int MAX_PERIODS    = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [N_NEURONS-1:0]       pattern,
  input  logic [N_NEURONS*PHI_W-1:0] phi_in,
  output logic                       ser_bit,
  output logic                       ser_shift,
  output logic                       re,
  output logic                       full_tick,
  output logic                       busy,
  output logic                       done,
  output logic                       converged,
  output logic [N_NEURONS*PHI_W-1:0] result,
  output logic [7:0]                 periods
);

  localparam int VEC_W  = N_NEURONS * PHI_W;
  localparam int LOAD_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [LOAD_W-1:0] LOAD_LAST  = LOAD_W'(N_NEURONS - 1);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [7:0]        PERIOD_MAX = 8'(MAX_PERIODS);

  state_e              state_q, state_d;
  logic [N_NEURONS-1:0] shreg_q, shreg_d;
  logic [LOAD_W-1:0]   load_cnt_q, load_cnt_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [7:0]          periods_q, periods_d;
  logic                converged_q, converged_d;
  logic [VEC_W-1:0]    result_q, result_d;

  logic                start_acc;
  logic                check_stb;
  logic                stable;
  logic [VEC_W-1:0]    phi_view;
  logic [TICK_W-1:0]   tick_inc;

  assign start_acc = (state_q == IDLE) && start;
  assign check_stb = (state_q == CHECK);
  // The period counter free-runs through RUN and CHECK so the CHECK cycle
  // does not stretch the oscillation period.
  assign tick_inc  = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;

  onn_stability_checker #(
    .N_NEURONS      (N_NEURONS),
    .PHI_W          (PHI_W),
    .STABLE_PERIODS (STABLE_PERIODS)
  ) u_checker (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_acc),
    .check    (check_stb),
    .phi_in   (phi_in),
    .stable   (stable),
    .phi_view (phi_view)
  );

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    load_cnt_d  = load_cnt_q;
    tick_cnt_d  = tick_cnt_q;
    periods_d   = periods_q;
    converged_d = converged_q;
    result_d    = result_q;
    ser_shift   = 1'b0;
    re          = 1'b0;
    full_tick   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          shreg_d     = pattern;
          load_cnt_d  = '0;
          tick_cnt_d  = '0;
          periods_d   = '0;
          converged_d = 1'b0;
          result_d    = '0;
        end
      end
      LOAD: begin
        busy       = 1'b1;
        ser_shift  = 1'b1;
        // MSB leaves first so that after N shifts bit i sits in neuron i.
        shreg_d    = shreg_q << 1;
        load_cnt_d = load_cnt_q + 1'b1;
        if (load_cnt_q == LOAD_LAST) begin
          state_d    = RUN;
          tick_cnt_d = '0;
        end
      end
      RUN: begin
        busy       = 1'b1;
        re         = 1'b1;
        tick_cnt_d = tick_inc;
        if (tick_cnt_q == TICK_LAST) begin
          full_tick = 1'b1;
          periods_d = (periods_q == 8'hFF) ? periods_q : periods_q + 8'd1;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        busy       = 1'b1;
        re         = 1'b1;
        tick_cnt_d = tick_inc;
        // Convergence wins over a coincident timeout.
        if (stable) begin
          converged_d = 1'b1;
          state_d     = FIN;
        end else if (periods_q == PERIOD_MAX) begin
          converged_d = 1'b0;
          state_d     = FIN;
        end else begin
          state_d     = RUN;
        end
      end
      FIN: begin
        done     = 1'b1;
        result_d = phi_view;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ser_bit   = (state_q == LOAD) && shreg_q[N_NEURONS-1];
  assign converged = converged_q;
  assign result    = result_q;
  assign periods   = periods_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      load_cnt_q  <= '0;
      tick_cnt_q  <= '0;
      periods_q   <= '0;
      converged_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      load_cnt_q  <= load_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      periods_q   <= periods_d;
      converged_q <= converged_d;
      result_q    <= result_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_onn_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_onn_run_controller
// Description : Self-checking bench for onn_run_controller. A table of run
//               scenarios (pattern, phase behaviour, expected outcome) is
//               applied in a loop; reset and mid-run reset are hand-written.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onn_run_controller;

  localparam int N        = 15;
  localparam int PW       = 4;
  localparam int VW       = N * PW;
  localparam int TICK_DIV = 16;
  localparam int STABLE   = 4;
  localparam int MAXP     = 10;

  localparam int M_CONST  = 0;
  localparam int M_OSC    = 1;
  localparam int M_ROT    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  pattern;
  logic [VW-1:0] phi_in;
  logic          ser_bit, ser_shift, re, full_tick, busy, done, converged;
  logic [VW-1:0] result;
  logic [7:0]    periods;

  int n_tests = 0;
  int n_fail  = 0;

  onn_run_controller #(
    .N_NEURONS      (N),
    .PHI_W          (PW),
    .TICK_DIV       (TICK_DIV),
    .STABLE_PERIODS (STABLE),
    .MAX_PERIODS    (MAXP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pattern   (pattern),
    .phi_in    (phi_in),
    .ser_bit   (ser_bit),
    .ser_shift (ser_shift),
    .re        (re),
    .full_tick (full_tick),
    .busy      (busy),
    .done      (done),
    .converged (converged),
    .result    (result),
    .periods   (periods)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  pattern;
    int            mode;
    logic [VW-1:0] base;
    bit            poke;
    bit            exp_conv;
    int            exp_periods;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Phase vector presented by the bench bank model after k periods.
  function automatic logic [VW-1:0] phase_vec(input int mode, input logic [VW-1:0] base, input int k);
    logic [VW-1:0] v;
    v = base;
    if (mode == M_OSC && (k % 2) == 1) v = ~base;
    if (mode == M_ROT)
      for (int i = 0; i < N; i++) v[i*PW +: PW] = base[i*PW +: PW] + PW'(k);
    return v;
  endfunction

  function automatic logic [VW-1:0] view_of(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = v;
`ifdef ONN_RELPHASE_EN
    for (int i = 0; i < N; i++) r[i*PW +: PW] = v[i*PW +: PW] - v[PW-1:0];
`endif
    return r;
  endfunction

  task automatic run_scenario(input vec_t v, input string tag);
    logic [N-1:0]  seq;
    int            nshift;
    bit            overlap;
    int            ticks, last;
    bit            done_seen, spacing_bad, poked;
    logic [VW-1:0] exp_res;

    @(negedge clk);
    pattern = v.pattern;
    phi_in  = phase_vec(v.mode, v.base, 0);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_load_busy"}, 64'(busy), 64'd1);
    chk({tag, "_load_clear"}, 64'({converged, periods}), 64'd0);

    seq = '0; nshift = 0; overlap = 1'b0;
    for (int c = 0; c < 40 && !re; c++) begin
      if (ser_shift) begin
        seq = {seq[N-2:0], ser_bit};
        nshift++;
        if (re) overlap = 1'b1;
      end
      @(negedge clk);
    end
    chk({tag, "_shift_count"}, 64'(nshift), 64'(N));
    chk({tag, "_ser_seq"}, 64'(seq), 64'(v.pattern));
    chk({tag, "_shift_in_run"}, 64'(ser_shift | overlap), 64'd0);

    ticks = 0; last = 0; done_seen = 1'b0; spacing_bad = 1'b0; poked = 1'b0;
    for (int c = 0; c < 600 && !done_seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (full_tick) begin
        if (!re) spacing_bad = 1'b1;
        if (ticks > 0 && (c - last) != TICK_DIV) spacing_bad = 1'b1;
        last  = c;
        ticks++;
        phi_in = phase_vec(v.mode, v.base, ticks);
      end else if (v.poke && ticks == 2 && !poked) begin
        start = 1'b1;
        poked = 1'b1;
      end
      if (done) begin
        done_seen = 1'b1;
        chk({tag, "_converged"}, 64'(converged), 64'(v.exp_conv));
        chk({tag, "_fin_busy_re"}, 64'({busy, re}), 64'd0);
        if (v.poke) start = 1'b1;
      end
    end

    if (!done_seen) begin
      chk({tag, "_done_timeout"}, 64'd0, 64'd1);
    end else begin
      exp_res = view_of(phase_vec(v.mode, v.base, v.exp_periods));
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_periods"}, 64'(periods), 64'(v.exp_periods));
      chk({tag, "_tick_count"}, 64'(ticks), 64'(v.exp_periods));
      chk({tag, "_tick_spacing"}, 64'(spacing_bad), 64'd0);
      chk({tag, "_result"}, 64'(result), 64'(exp_res));
      chk({tag, "_idle_done"}, 64'({busy, done}), 64'd0);
      @(negedge clk);
      chk({tag, "_idle_hold"}, 64'({busy, ser_shift, re}), 64'd0);
      chk({tag, "_held_periods"}, 64'(periods), 64'(v.exp_periods));
    end
  endtask

  initial begin
    int ticks;

    tbl[0] = '{pattern: 15'h5A5A, mode: M_CONST, base: 60'h123456789ABCDEF,
               poke: 1'b0, exp_conv: 1'b1, exp_periods: 5};
    tbl[1] = '{pattern: 15'h1234, mode: M_OSC, base: 60'h123456789ABCDEF,
               poke: 1'b0, exp_conv: 1'b0, exp_periods: MAXP};
`ifdef ONN_RELPHASE_EN
    tbl[2] = '{pattern: 15'h7FFF, mode: M_ROT, base: 60'hFEDCBA987654321,
               poke: 1'b0, exp_conv: 1'b1, exp_periods: 5};
`else
    tbl[2] = '{pattern: 15'h7FFF, mode: M_ROT, base: 60'hFEDCBA987654321,
               poke: 1'b0, exp_conv: 1'b0, exp_periods: MAXP};
`endif
    tbl[3] = '{pattern: 15'h0001, mode: M_CONST, base: 60'h0F0F0F0F0F0F0F0,
               poke: 1'b1, exp_conv: 1'b1, exp_periods: 5};

    rst_n   = 1'b0;
    start   = 1'b0;
    pattern = '0;
    phi_in  = '0;
    #12;
    chk("rst_ctrl", 64'({ser_bit, ser_shift, re, full_tick, busy, done, converged}), 64'd0);
    chk("rst_periods", 64'(periods), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_scenario(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a run, at the third period strobe.
    @(negedge clk);
    pattern = 15'h2AAA;
    phi_in  = tbl[0].base;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ticks = 0;
    for (int c = 0; c < 200 && ticks < 3; c++) begin
      @(negedge clk);
      if (full_tick) ticks++;
    end
    chk("midrst_pre", 64'({re, full_tick, busy}), 64'b111);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_async", 64'({re, full_tick, busy, ser_shift, done}), 64'd0);
    chk("midrst_periods", 64'(periods), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_scenario(tbl[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
